axis_period_generator: RTL and testbench

AXIS_PERIOD_GENERATOR -- requirements
Module: axis_period_generator

---
 rtl/axis_period_generator_pkg.sv | 17 +
 rtl/half_period_toggler.sv | 69 ++++++
 rtl/axis_period_generator.sv | 204 ++++++++++++++++++++
 tb/tb_axis_period_generator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/axis_period_generator_pkg.sv
// Shared definitions for the AXI-Stream two-channel period generator:
// FSM state encoding, default widths and the continuous-burst sentinel.
package axis_period_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int DEF_ADC_WIDTH   = 14;
  localparam int DEF_COUNT_WIDTH = 32;

  // Ncycles value meaning "run until stopped"; every bit set.
  localparam logic [DEF_COUNT_WIDTH-1:0] NCYCLES_CONTINUOUS = '1;

endpackage

// File: rtl/half_period_toggler.sv
// One output channel: optional start-up delay, then LOW/HIGH toggling every
// half_period accepted beats. The level registers only move on adv_i, so the
// selected level is stable while the stream is stalled.
module half_period_toggler
  import axis_period_generator_pkg::*;
#(
  parameter int ADC_WIDTH   = DEF_ADC_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          init_i,
  input  logic                          adv_i,
  input  logic [COUNT_WIDTH-1:0]        half_period_i,
  input  logic [COUNT_WIDTH-1:0]        delay_i,
  input  logic signed [ADC_WIDTH-1:0]   high_level_i,
  input  logic signed [ADC_WIDTH-1:0]   low_level_i,
  output logic signed [ADC_WIDTH-1:0]   level_o,
  output logic                          period_end_o
);

  logic [COUNT_WIDTH-1:0] delay_q, delay_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   high_q, high_d;
  logic                   in_delay;
  logic                   last_of_half;

  assign in_delay     = (delay_q != '0);
  assign last_of_half = !in_delay && (cnt_q == half_period_i - 1'b1);

  // Counter state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      delay_q <= '0;
      cnt_q   <= '0;
      high_q  <= 1'b0;
    end else begin
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
    end
  end

  // Delay countdown, then half-period counting with a level flip on wrap
  always_comb begin
    delay_d = delay_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    if (init_i) begin
      delay_d = delay_i;
      cnt_d   = '0;
      high_d  = 1'b0;
    end else if (adv_i) begin
      if (in_delay) begin
        delay_d = delay_q - 1'b1;
      end else if (last_of_half) begin
        cnt_d  = '0;
        high_d = ~high_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o      = high_q ? high_level_i : low_level_i;
  // Beat that finishes a HIGH half closes one full period of this channel.
  assign period_end_o = adv_i && !init_i && high_q && last_of_half;

endmodule

// File: rtl/axis_period_generator.sv
// Burst generator of two square waves on an AXI-Stream master port.
// CH1 sits in the low half-word, CH2 (phase-delayed) in the high half-word.
// Optional feature: define AXIS_PERIOD_GENERATOR_NOISE_EN to add a small
// LFSR-driven dither to both channels (saturated to the sample width).
module axis_period_generator
  import axis_period_generator_pkg::*;
#(
  parameter int ADC_WIDTH        = DEF_ADC_WIDTH,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [COUNT_WIDTH-1:0]        half_period,
  input  logic [COUNT_WIDTH-1:0]        phase_delay,
  input  logic [COUNT_WIDTH-1:0]        Ncycles,
  input  logic signed [ADC_WIDTH-1:0]   HIGH_LEVEL_CH1,
  input  logic signed [ADC_WIDTH-1:0]   LOW_LEVEL_CH1,
  input  logic signed [ADC_WIDTH-1:0]   HIGH_LEVEL_CH2,
  input  logic signed [ADC_WIDTH-1:0]   LOW_LEVEL_CH2,
  output logic [AXIS_TDATA_WIDTH-1:0]   M_AXIS_OUT_tdata,
  output logic                          M_AXIS_OUT_tvalid,
  input  logic                          M_AXIS_OUT_tready,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT_WIDTH-1:0]        cycles_sent
);

  localparam int HALF_WIDTH = AXIS_TDATA_WIDTH / 2;
  localparam logic [COUNT_WIDTH-1:0] CONT_SENTINEL = {COUNT_WIDTH{NCYCLES_CONTINUOUS[0]}};
  localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic                   tvalid_q, tvalid_d;
  logic                   stop_q, stop_d;
  logic [COUNT_WIDTH-1:0] cycles_q, cycles_d;
  logic                   latch_en;

  logic [COUNT_WIDTH-1:0]        hp_q;
  logic [COUNT_WIDTH-1:0]        nc_q;
  logic signed [ADC_WIDTH-1:0]   hi1_q, lo1_q, hi2_q, lo2_q;

  logic                          accept;
  logic                          adv;
  logic                          period_end;
  logic [COUNT_WIDTH-1:0]        cycles_inc;
  logic                          count_hit;
  logic signed [ADC_WIDTH-1:0]   ch1_lvl, ch2_lvl, ch1_out, ch2_out;

  assign accept     = tvalid_q && M_AXIS_OUT_tready;
  assign adv        = (state_q == ST_RUN) && accept;
  assign latch_en   = (state_q == ST_IDLE) && start;
  assign cycles_inc = cycles_q + 1'b1;
  assign count_hit  = (nc_q != CONT_SENTINEL) && (cycles_inc == (ONE << nc_q));

  // Configuration snapshot taken on the accepted start pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp_q  <= '0;
      nc_q  <= '0;
      hi1_q <= '0;
      lo1_q <= '0;
      hi2_q <= '0;
      lo2_q <= '0;
    end else if (latch_en) begin
      hp_q  <= (half_period == '0) ? ONE : half_period;
      nc_q  <= Ncycles;
      hi1_q <= HIGH_LEVEL_CH1;
      lo1_q <= LOW_LEVEL_CH1;
      hi2_q <= HIGH_LEVEL_CH2;
      lo2_q <= LOW_LEVEL_CH2;
    end
  end

  // CH1 defines period boundaries; the phase delay is loaded straight from
  // the input because the toggler captures it on the same start edge.
  half_period_toggler #(
    .ADC_WIDTH  (ADC_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_ch1 (
    .clk_i        (clk),
    .rst_ni       (rst),
    .init_i       (latch_en),
    .adv_i        (adv),
    .half_period_i(hp_q),
    .delay_i      ('0),
    .high_level_i (hi1_q),
    .low_level_i  (lo1_q),
    .level_o      (ch1_lvl),
    .period_end_o (period_end)
  );

  half_period_toggler #(
    .ADC_WIDTH  (ADC_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_ch2 (
    .clk_i        (clk),
    .rst_ni       (rst),
    .init_i       (latch_en),
    .adv_i        (adv),
    .half_period_i(hp_q),
    .delay_i      (phase_delay),
    .high_level_i (hi2_q),
    .low_level_i  (lo2_q),
    .level_o      (ch2_lvl),
    .period_end_o ()
  );

  // FSM and burst bookkeeping state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      tvalid_q <= 1'b0;
      stop_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      stop_q   <= stop_d;
      cycles_q <= cycles_d;
    end
  end

  // Next-state logic: start burst, count periods, end on count or stop
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    stop_d   = stop_q;
    cycles_d = cycles_q;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          state_d  = ST_RUN;
          tvalid_d = 1'b1;
          cycles_d = '0;
        end
      end
      ST_RUN: begin
        if (stop) stop_d = 1'b1;
        if (period_end) begin
          cycles_d = cycles_inc;
          if (count_hit || stop_q || stop) begin
            state_d  = ST_FLUSH;
            tvalid_d = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        if (accept) tvalid_d = 1'b0;
        if (!tvalid_q) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef AXIS_PERIOD_GENERATOR_NOISE_EN
  logic [15:0] lfsr_q;

  function automatic logic signed [ADC_WIDTH-1:0] sat_add(
    input logic signed [ADC_WIDTH-1:0] a,
    input logic signed [2:0]           n
  );
    logic signed [ADC_WIDTH:0] s;
    s = {a[ADC_WIDTH-1], a} + {{(ADC_WIDTH-2){n[2]}}, n};
    if (s[ADC_WIDTH] != s[ADC_WIDTH-1])
      sat_add = s[ADC_WIDTH] ? {1'b1, {(ADC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ADC_WIDTH-1){1'b1}}};
    else
      sat_add = s[ADC_WIDTH-1:0];
  endfunction

  // Maximal 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), one step per beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 16'h0001;
    end else if (adv) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign ch1_out = sat_add(ch1_lvl, lfsr_q[2:0]);
  assign ch2_out = sat_add(ch2_lvl, lfsr_q[2:0]);
`else
  assign ch1_out = ch1_lvl;
  assign ch2_out = ch2_lvl;
`endif

  // Data is zeroed outside valid beats so reset and idle read as all-zero.
  assign M_AXIS_OUT_tdata = tvalid_q
    ? {{(HALF_WIDTH-ADC_WIDTH){ch2_out[ADC_WIDTH-1]}}, ch2_out,
       {(HALF_WIDTH-ADC_WIDTH){ch1_out[ADC_WIDTH-1]}}, ch1_out}
    : '0;
  assign M_AXIS_OUT_tvalid = tvalid_q;
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_FLUSH) && !tvalid_q;
  assign cycles_sent       = cycles_q;

endmodule

// File: tb/tb_axis_period_generator.sv
// Scoreboard bench for axis_period_generator (default build, no noise).
module tb_axis_period_generator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic [31:0]        half_period;
  logic [31:0]        phase_delay;
  logic [31:0]        Ncycles;
  logic signed [13:0] HIGH_LEVEL_CH1, LOW_LEVEL_CH1, HIGH_LEVEL_CH2, LOW_LEVEL_CH2;
  logic [31:0]        M_AXIS_OUT_tdata;
  logic               M_AXIS_OUT_tvalid;
  logic               M_AXIS_OUT_tready;
  logic               busy;
  logic               done;
  logic [31:0]        cycles_sent;

  localparam logic signed [13:0] H1 = 14'sd1000;
  localparam logic signed [13:0] L1 = -14'sd1000;
  localparam logic signed [13:0] H2 = 14'sd500;
  localparam logic signed [13:0] L2 = -14'sd300;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  axis_period_generator dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .stop             (stop),
    .half_period      (half_period),
    .phase_delay      (phase_delay),
    .Ncycles          (Ncycles),
    .HIGH_LEVEL_CH1   (HIGH_LEVEL_CH1),
    .LOW_LEVEL_CH1    (LOW_LEVEL_CH1),
    .HIGH_LEVEL_CH2   (HIGH_LEVEL_CH2),
    .LOW_LEVEL_CH2    (LOW_LEVEL_CH2),
    .M_AXIS_OUT_tdata (M_AXIS_OUT_tdata),
    .M_AXIS_OUT_tvalid(M_AXIS_OUT_tvalid),
    .M_AXIS_OUT_tready(M_AXIS_OUT_tready),
    .busy             (busy),
    .done             (done),
    .cycles_sent      (cycles_sent)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] pack(input logic signed [13:0] a, input logic signed [13:0] b);
    return {{2{b[13]}}, b, {2{a[13]}}, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes the expected beats, runs one burst and checks it beat by beat.
  task automatic run_burst(input string name, input int hp, input int pd,
                           input logic [31:0] nc, input int stop_at,
                           input bit stall_mode, input int n_beats,
                           input int exp_cycles, input bit restart_mid);
    int          hpe;
    int          acc;
    bit          got_done;
    bit          stalled;
    logic [31:0] held;
    logic [31:0] expv;
    bit          c1h, c2h;
    hpe = (hp == 0) ? 1 : hp;
    for (int k = 0; k < n_beats; k++) begin
      c1h = ((k / hpe) % 2) == 1;
      c2h = (k < pd) ? 1'b0 : ((((k - pd) / hpe) % 2) == 1);
      exp_q.push_back(pack(c1h ? H1 : L1, c2h ? H2 : L2));
    end
    half_period = hp; phase_delay = pd; Ncycles = nc;
    HIGH_LEVEL_CH1 = H1; LOW_LEVEL_CH1 = L1; HIGH_LEVEL_CH2 = H2; LOW_LEVEL_CH2 = L2;
    M_AXIS_OUT_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Inputs changed after start must not affect the running burst.
    half_period = 9; phase_delay = 5; Ncycles = 0;
    HIGH_LEVEL_CH1 = 14'sd7; LOW_LEVEL_CH1 = 14'sd3; HIGH_LEVEL_CH2 = 14'sd9; LOW_LEVEL_CH2 = 14'sd1;
    check_eq({name, "_tvalid_rise"}, M_AXIS_OUT_tvalid, 1);
    acc = 0; got_done = 0; stalled = 0; held = '0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      M_AXIS_OUT_tready = stall_mode ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      stop  = (stop_at > 0) && (acc == stop_at - 1) && M_AXIS_OUT_tvalid;
      start = restart_mid && (cyc == 3);
      if (cyc == 1) check_eq({name, "_busy"}, busy, 1);
      if (stalled) check_eq({name, "_stable"}, M_AXIS_OUT_tdata, held);
      if (done) begin
        got_done = 1;
        check_eq({name, "_cycles_sent"}, cycles_sent, exp_cycles);
        check_eq({name, "_beats"}, acc, n_beats);
        check_eq({name, "_tvalid_end"}, M_AXIS_OUT_tvalid, 0);
      end else if (M_AXIS_OUT_tvalid && M_AXIS_OUT_tready) begin
        if (exp_q.size() == 0) begin
          check_eq({name, "_extra_beat"}, 1, 0);
        end else begin
          expv = exp_q.pop_front();
          check_eq({name, "_beat"}, M_AXIS_OUT_tdata, expv);
        end
        acc++;
      end
      stalled = M_AXIS_OUT_tvalid && !M_AXIS_OUT_tready;
      held    = M_AXIS_OUT_tdata;
      tick();
    end
    stop = 1'b0; start = 1'b0; M_AXIS_OUT_tready = 1'b1;
    if (!got_done) check_eq({name, "_done_timeout"}, 0, 1);
    check_eq({name, "_done_one_cycle"}, done, 0);
    check_eq({name, "_idle_busy"}, busy, 0);
    exp_q.delete();
    $display("burst %s: beats=%0d cycles_sent=%0d", name, acc, cycles_sent);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b0; start = 1'b0; stop = 1'b0; M_AXIS_OUT_tready = 1'b1;
    half_period = 0; phase_delay = 0; Ncycles = 0;
    HIGH_LEVEL_CH1 = 0; LOW_LEVEL_CH1 = 0; HIGH_LEVEL_CH2 = 0; LOW_LEVEL_CH2 = 0;
    tick(); tick();
    check_eq("rst_tvalid", M_AXIS_OUT_tvalid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_tdata", M_AXIS_OUT_tdata, 0);
    check_eq("rst_cycles", cycles_sent, 0);
    rst = 1'b1;
    tick();

    run_burst("basic", 4, 0, 1, 0, 0, 16, 2, 1);
    run_burst("phase", 3, 2, 1, 0, 0, 12, 2, 0);
    run_burst("stall", 4, 0, 1, 0, 1, 16, 2, 0);
    run_burst("stop", 4, 0, 32'hFFFF_FFFF, 5, 0, 8, 1, 0);

    // Stop while idle must not shorten the next burst.
    stop = 1'b1; tick(); stop = 1'b0; tick();
    check_eq("idle_stop_busy", busy, 0);
    run_burst("hp_zero", 0, 0, 2, 0, 0, 8, 4, 0);

    // Asynchronous reset in the middle of a burst.
    half_period = 4; phase_delay = 0; Ncycles = 1;
    HIGH_LEVEL_CH1 = H1; LOW_LEVEL_CH1 = L1; HIGH_LEVEL_CH2 = H2; LOW_LEVEL_CH2 = L2;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #2;
    check_eq("mid_rst_tvalid", M_AXIS_OUT_tvalid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_tdata", M_AXIS_OUT_tdata, 0);
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) saw_done = 1;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) saw_done = 1;
    end
    check_eq("mid_rst_no_done", saw_done, 0);
    check_eq("mid_rst_cycles", cycles_sent, 0);
    run_burst("after_rst", 4, 0, 1, 0, 0, 16, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
